boa_lsu: RTL and testbench

- Parametrised load/store unit: takes one RV32 load/store request, runs it on the data bus as one or two word accesses, returns a one-cycle response.
- Extracts and sign- or zero-extends byte/halfword loads.
- Replaces the combinational memory helper of the MEM stage.
- Adds a request/response handshake, bus timeout detection and optional split misaligned accesses.

---
 rtl/boa_lsu_if.sv | 13 +
 rtl/boa_lsu.sv | 196 +++++++++++++++++++
 tb/tb_boa_lsu.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/boa_lsu_if.sv
// Word-addressed data bus between the LSU and data memory.
// Read data follows one cycle after an accepted read.
interface boa_mem_bus;
    logic [31:2] addr;
    logic        re;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport CPU (output addr, re, we, wdata, input rdata, ready);
    modport MEM (input addr, re, we, wdata, output rdata, ready);
endinterface

// File: rtl/boa_lsu.sv
// RV32 load/store unit: one request -> one or two bus words -> one-cycle response pulse (optional split misaligned: BOA_LSU_MISALIGN_EN).
// Latency from accept: trap 1, aligned store 2, aligned load 3 cycles, plus bus wait states.
// Backpressure: req_ready only in IDLE; bus access held until ready, aborted by clear or TIMEOUT_CYC.
module boa_lsu #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_trap,
    output logic [3:0]  resp_cause,
    boa_mem_bus.CPU     dbus
);
    localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
`ifdef BOA_LSU_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ISSUE0, DATA0, ISSUE1, DATA1} state_t;
    state_t state, state_n;

    logic          r_we;
    logic [2:0]    r_f3;
    logic [31:0]   r_addr, r_wdata;
    logic [63:0]   asm_q, asm_n;
    logic [CW-1:0] cnt;

    logic [1:0]  size;
    logic        illegal, misal;
    logic [31:0] rep, rot;
    logic [5:0]  bsh;
    logic [7:0]  lanes;
    logic        split, issuing, hi, timeout_hit;
    logic [31:0] ld_raw;
    logic        acc, cnt_clr, cnt_inc, resp_load, resp_trap_n;
    logic [31:0] resp_rdata_n;
    logic [3:0]  resp_cause_n;

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return f3[2] ? {24'b0, v[7:0]}   : {{24{v[7]}}, v[7:0]};
            2'd1:    return f3[2] ? {16'b0, v[15:0]}  : {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Request decode
    assign size    = req_funct3[1:0];
    assign illegal = (size == 2'd3) || (!req_we && req_funct3 == 3'b110) || (req_we && req_funct3[2]);
    assign misal   = (size == 2'd1 && req_addr[0]) || (size == 2'd2 && req_addr[1:0] != 2'b00);

    // Replicate then rotate: one word carries the right byte in every lane of both halves of a split
    assign rep = (size == 2'd0) ? {4{req_wdata[7:0]}} :
                 (size == 2'd1) ? {2{req_wdata[15:0]}} : req_wdata;
    assign bsh = {1'b0, req_addr[1:0], 3'b000};
    assign rot = (rep << bsh) | (rep >> (6'd32 - bsh));

    assign lanes   = ((r_f3[1:0] == 2'd0) ? 8'h01 : (r_f3[1:0] == 2'd1) ? 8'h03 : 8'h0F) << r_addr[1:0];
    assign split   = |lanes[7:4];
    assign issuing = (state == ISSUE0) || (state == ISSUE1);
    assign hi      = (state == ISSUE1) || (state == DATA1);

    assign req_ready   = (state == IDLE) && !clear;
    assign dbus.addr   = r_addr[31:2] + 30'(hi);
    assign dbus.re     = issuing && !r_we;
    assign dbus.we     = (issuing && r_we) ? (hi ? lanes[7:4] : lanes[3:0]) : 4'b0000;
    assign dbus.wdata  = r_wdata;

    assign timeout_hit = (TIMEOUT_CYC != 0) && ((32'(cnt) + 32'd1) == TIMEOUT_CYC);

    always_comb begin
        asm_n = asm_q;
        for (int i = 0; i < 4; i++) begin
            if (state == DATA0 && lanes[i])     asm_n[8*i +: 8]      = dbus.rdata[8*i +: 8];
            if (state == DATA1 && lanes[i + 4]) asm_n[32 + 8*i +: 8] = dbus.rdata[8*i +: 8];
        end
    end

    assign ld_raw = 32'(asm_n >> {r_addr[1:0], 3'b000});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n      = state;
        acc          = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        resp_load    = 1'b0;
        resp_trap_n  = 1'b0;
        resp_cause_n = 4'd0;
        resp_rdata_n = 32'd0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    acc = 1'b1;
                    if (illegal) begin
                        resp_load    = 1'b1;
                        resp_trap_n  = 1'b1;
                        resp_cause_n = 4'd2;
                    end else if (misal && !MIS_EN) begin
                        resp_load    = 1'b1;
                        resp_trap_n  = 1'b1;
                        resp_cause_n = req_we ? 4'd6 : 4'd4;
                    end else begin
                        state_n = ISSUE0;
                        cnt_clr = 1'b1;
                    end
                end
            end
            ISSUE0, ISSUE1: begin
                if (dbus.ready) begin
                    if (!r_we) begin
                        state_n = (state == ISSUE0) ? DATA0 : DATA1;
                    end else if (state == ISSUE0 && split) begin
                        state_n = ISSUE1;
                        cnt_clr = 1'b1;
                    end else begin
                        state_n   = IDLE;
                        resp_load = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_n      = IDLE;
                    resp_load    = 1'b1;
                    resp_trap_n  = 1'b1;
                    resp_cause_n = r_we ? 4'd7 : 4'd5;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DATA0: begin
                if (split) begin
                    state_n = ISSUE1;
                    cnt_clr = 1'b1;
                end else begin
                    state_n      = IDLE;
                    resp_load    = 1'b1;
                    resp_rdata_n = extend(ld_raw, r_f3);
                end
            end
            DATA1: begin
                state_n      = IDLE;
                resp_load    = 1'b1;
                resp_rdata_n = extend(ld_raw, r_f3);
            end
            default: state_n = IDLE;
        endcase
        if (clear) begin
            state_n   = IDLE;
            resp_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we       <= 1'b0;
            r_f3       <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            asm_q      <= 64'd0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_trap  <= 1'b0;
            resp_cause <= 4'd0;
        end else begin
            if (acc) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= rot;
            end
            asm_q <= asm_n;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + CW'(1);
            resp_valid <= resp_load;
            if (resp_load) begin
                resp_rdata <= resp_rdata_n;
                resp_trap  <= resp_trap_n;
                resp_cause <= resp_cause_n;
            end
        end
    end
endmodule

// File: tb/tb_boa_lsu.sv
// Self-checking bench for boa_lsu: directed scenarios plus randomized requests checked against a byte-level memory model.
module tb_boa_lsu;
`ifdef BOA_LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, clear, req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_trap;
    logic [31:0] resp_rdata;
    logic [3:0]  resp_cause;

    boa_mem_bus bus ();

    boa_lsu #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_trap(resp_trap),
        .resp_cause(resp_cause), .dbus(bus)
    );

    always #5 clk = ~clk;

    // Bus slave: word memory, ready policy chosen per cycle
    logic [31:0] mem_w [0:1023];
    logic [7:0]  ref_mem [0:4095];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx;
    logic [31:0] pl_dat;
    int          rdy_mode = 1;
    int          stall_run = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        if (rdy_mode == 1)      bus.ready = 1'b1;
        else if (rdy_mode == 2) bus.ready = 1'b0;
        else if (stall_run >= 2) bus.ready = 1'b1;
        else                    bus.ready = ($urandom_range(0, 2) != 0);
        stall_run = bus.ready ? 0 : stall_run + 1;
    end

    always @(posedge clk) begin
        if (pl_en) mem_w[pl_idx] <= pl_dat;
        else begin
            if (bus.ready && bus.re) bus.rdata <= mem_w[bus.addr[11:2]];
            if (bus.ready && bus.we != 4'b0000)
                mem_w[bus.addr[11:2]] <= merge(mem_w[bus.addr[11:2]], bus.wdata, bus.we);
        end
    end

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) ref_mem[(a[11:0] & 12'hFFC) + 12'(i)] = w[8*i +: 8];
        pl_idx = a[11:2];
        pl_dat = w;
        pl_en  = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Reference: what the architecture says a load/store should return
    logic        e_trap;
    logic [3:0]  e_cause;
    logic [31:0] e_rdata;

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int          n;
        logic [31:0] v;
        n = 1 << f3[1:0];
        e_trap = 1'b0; e_cause = 4'd0; e_rdata = 32'd0;
        if (f3[1:0] == 2'd3 || (!we && f3 == 3'b110) || (we && f3[2])) begin
            e_trap = 1'b1; e_cause = 4'd2;
        end else if ((a % n) != 0 && !MIS) begin
            e_trap = 1'b1; e_cause = we ? 4'd6 : 4'd4;
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_mem[12'(a + i)] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[12'(a + i)]) << (8 * i));
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e_rdata = v;
        end
    endtask

    typedef struct {
        int          k;
        logic        re;
        logic [3:0]  we;
        logic [29:0] addr;
        logic [31:0] wd;
    } bev_t;
    bev_t blog[$];

    logic        got_v;
    int          lat;
    logic [31:0] o_rdata;
    logic        o_trap;
    logic [3:0]  o_cause;

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int w;
        blog.delete();
        got_v = 1'b0; lat = 0; o_rdata = 32'd0; o_trap = 1'b0; o_cause = 4'd0;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (bus.re || bus.we != 4'b0000) blog.push_back('{k, bus.re, bus.we, bus.addr, bus.wdata});
            if (resp_valid) begin
                got_v = 1'b1; lat = k;
                o_rdata = resp_rdata; o_trap = resp_trap; o_cause = resp_cause;
                break;
            end
        end
    endtask

    function automatic int first_k();
        return (blog.size() > 0) ? blog[0].k : -1;
    endfunction

    initial begin
        int          nwe;
        logic        seen;
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] ra, rwd;

        rst = 1'b0; clear = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        pl_idx = 10'd0; pl_dat = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_trap", resp_trap, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_cause", resp_cause, 0);
        check("rst_bus_re", bus.re, 0);
        check("rst_bus_we", bus.we, 0);

        for (int i = 0; i < 32; i++) preload(32'h1000 + 32'(4 * i), $urandom);
        preload(32'h100, 32'h80FF1234);
        preload(32'h200, 32'hBEEF0000);
        preload(32'h1000, 32'h44332211);
        preload(32'h1004, 32'h88776655);
        @(negedge clk);
        rst = 1'b1;

        // LB sign-extended from the top lane
        model(1'b0, 3'b000, 32'h103, 32'd0);
        run_req(1'b0, 3'b000, 32'h103, 32'd0);
        check("lb_valid", got_v, 1);
        check("lb_latency", lat, 3);
        check("lb_rdata", o_rdata, 32'hFFFFFF80);
        check("lb_model", o_rdata, e_rdata);
        check("lb_re_cycle", first_k(), 1);
        check("lb_bus_addr", (blog.size() > 0) ? 32'(blog[0].addr) : 32'hDEAD, 32'h40);

        // LHU zero-extended
        model(1'b0, 3'b101, 32'h202, 32'd0);
        run_req(1'b0, 3'b101, 32'h202, 32'd0);
        check("lhu_rdata", o_rdata, 32'h0000BEEF);
        check("lhu_trap", o_trap, 0);

        // SH to upper half: lanes 1100, data replicated
        model(1'b1, 3'b001, 32'h302, 32'h0000ABCD);
        run_req(1'b1, 3'b001, 32'h302, 32'h0000ABCD);
        check("sh_latency", lat, 2);
        check("sh_we_cycle", first_k(), 1);
        check("sh_we", (blog.size() > 0) ? 32'(blog[0].we) : 32'hDEAD, 32'hC);
        check("sh_wdata", (blog.size() > 0) ? blog[0].wd : 32'hDEAD, 32'hABCDABCD);
        check("sh_rdata_zero", o_rdata, 0);
        model(1'b0, 3'b001, 32'h300, 32'd0);
        run_req(1'b0, 3'b001, 32'h302, 32'd0);
        check("sh_readback", o_rdata, 32'hFFFFABCD);

        // Word load across a word boundary
        model(1'b0, 3'b010, 32'h1001, 32'd0);
        run_req(1'b0, 3'b010, 32'h1001, 32'd0);
        if (MIS) begin
            check("lw_mis_rdata", o_rdata, 32'h55443322);
            check("lw_mis_addr0", (blog.size() > 0) ? 32'(blog[0].addr) : 32'hDEAD, 32'h400);
            check("lw_mis_addr1", (blog.size() > 1) ? 32'(blog[blog.size()-1].addr) : 32'hDEAD, 32'h401);
        end else begin
            check("lw_mis_trap", o_trap, 1);
            check("lw_mis_cause", o_cause, 4);
            check("lw_mis_latency", lat, 1);
            check("lw_mis_no_bus", blog.size(), 0);
        end
        check("lw_mis_model", o_rdata, e_rdata);

        // Bus never ready: timeout after 4 ISSUE cycles
        rdy_mode = 2;
        run_req(1'b1, 3'b010, 32'h1008, 32'h12345678);
        rdy_mode = 1;
        nwe = 0;
        foreach (blog[i]) if (blog[i].we != 4'b0000) nwe++;
        check("to_we_cycles", nwe, 4);
        check("to_trap", o_trap, 1);
        check("to_cause", o_cause, 7);
        check("to_latency", lat, 5);

        // clear during DATA0 of a load
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1010; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        seen = 1'b0;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) check("clr_req_ready", req_ready, 1);
            if (resp_valid) seen = 1'b1;
        end
        check("clr_no_resp", seen, 0);
        model(1'b0, 3'b010, 32'h1010, 32'd0);
        run_req(1'b0, 3'b010, 32'h1010, 32'd0);
        check("clr_next_valid", got_v, 1);
        check("clr_next_rdata", o_rdata, e_rdata);

        // Randomized traffic with random bus stalls
        rdy_mode = 0;
        for (int t = 0; t < 150; t++) begin
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = 32'h1000 + 32'($urandom_range(0, 63));
            rwd = $urandom;
            model(rwe, rf3, ra, rwd);
            run_req(rwe, rf3, ra, rwd);
            check("rnd_valid", got_v, 1);
            check("rnd_trap", o_trap, e_trap);
            if (e_trap) check("rnd_cause", o_cause, e_cause);
            check("rnd_rdata", o_rdata, e_rdata);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
